alu: RTL and testbench



---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_core.sv | 57 +++++
 rtl/alu.sv | 48 ++++
 tb/tb_alu.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and widths for the 16-bit SAP ALU.
package alu_pkg;

  localparam int DATA_W = 16;
  localparam int RES_W  = 17;

  // Controller opcodes; 12..15 all decode as reserved.
  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_NOT   = 4'd5,
    OP_SHL   = 4'd6,
    OP_SHR   = 4'd7,
    OP_INC   = 4'd8,
    OP_DEC   = 4'd9,
    OP_PASSA = 4'd10,
    OP_PASSB = 4'd11,
    OP_RSVD  = 4'd12
  } op_e;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: next result and status flags.
module alu_core
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        op,
  output logic [RES_W-1:0]  next_res,
  output logic              next_zf,
  output logic              next_sf,
  output logic              next_cf,
  output logic              next_vf
);

  op_e opc;
  assign opc = op_e'(op);

  // Result select; bit 16 carries carry/borrow/shift-out, vf only for arithmetic.
  always_comb begin
    next_res = '0;
    next_vf  = 1'b0;
    case (opc)
      OP_ADD: begin
        next_res = {1'b0, a} + {1'b0, b};
        next_vf  = (a[15] == b[15]) && (next_res[15] != a[15]);
      end
      OP_SUB: begin
        // Borrow lands in bit 16 because the 17-bit difference wraps.
        next_res = {1'b0, a} - {1'b0, b};
        next_vf  = (a[15] != b[15]) && (next_res[15] != a[15]);
      end
      OP_AND:   next_res = {1'b0, a & b};
      OP_OR:    next_res = {1'b0, a | b};
      OP_XOR:   next_res = {1'b0, a ^ b};
      OP_NOT:   next_res = {1'b0, ~a};
      // 17-bit shift leaves the last bit shifted out in bit 16 (0 for a zero shift).
      OP_SHL:   next_res = {1'b0, a} << b[3:0];
      OP_SHR:   next_res = {1'b0, a >> b[3:0]};
      OP_INC: begin
        next_res = {1'b0, a} + 17'd1;
        next_vf  = !a[15] && next_res[15];
      end
      OP_DEC: begin
        next_res = {1'b0, a} - 17'd1;
        next_vf  = a[15] && !next_res[15];
      end
      OP_PASSA: next_res = {1'b0, a};
      OP_PASSB: next_res = {1'b0, b};
      default:  next_res = '0;
    endcase
  end

  assign next_zf = (next_res[15:0] == 16'h0000);
  assign next_sf = next_res[15];
  assign next_cf = next_res[16];

endmodule

// File: rtl/alu.sv
// Registered 16-bit ALU: combinational core followed by one output register.
module alu
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        op,
  output logic [RES_W-1:0]  res,
  output logic              zf,
  output logic              sf,
  output logic              cf,
  output logic              vf
);

  logic [RES_W-1:0] next_res;
  logic             next_zf, next_sf, next_cf, next_vf;

  alu_core u_core (
    .a        (a),
    .b        (b),
    .op       (op),
    .next_res (next_res),
    .next_zf  (next_zf),
    .next_sf  (next_sf),
    .next_cf  (next_cf),
    .next_vf  (next_vf)
  );

  // Capture result and flags each edge; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res <= '0;
      zf  <= 1'b0;
      sf  <= 1'b0;
      cf  <= 1'b0;
      vf  <= 1'b0;
    end else begin
      res <= next_res;
      zf  <= next_zf;
      sf  <= next_sf;
      cf  <= next_cf;
      vf  <= next_vf;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed corner cases plus randomized model checks.
module tb_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a, b;
  logic [3:0]  op;
  logic [16:0] res;
  logic        zf, sf, cf, vf;

  int nvec = 0;
  int nerr = 0;

  alu dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .op  (op),
    .res (res),
    .zf  (zf),
    .sf  (sf),
    .cf  (cf),
    .vf  (vf)
  );

  always #5 clk = ~clk;

  // Observed vector: {res, zf, sf, cf, vf}
  function automatic logic [20:0] obs();
    return {res, zf, sf, cf, vf};
  endfunction

  function automatic logic [20:0] mk(input logic [16:0] r, input logic z, s, c, v);
    return {r, z, s, c, v};
  endfunction

  task automatic chk(input string tag, input logic [20:0] got, input logic [20:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got res=%h z%0b s%0b c%0b v%0b, expected res=%h z%0b s%0b c%0b v%0b",
               tag, got[20:4], got[3], got[2], got[1], got[0],
               exp[20:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Reference model: integer arithmetic straight from the opcode definitions.
  function automatic logic [20:0] ref_model(input logic [15:0] ra, rb, input logic [3:0] rop);
    int ua, ub, sa, sb, r, s, n;
    logic [16:0] rr;
    logic v;
    ua = int'(ra); ub = int'(rb);
    sa = int'($signed(ra)); sb = int'($signed(rb));
    n  = int'(rb[3:0]);
    v  = 1'b0;
    rr = '0;
    case (rop)
      4'd0: begin r = ua + ub; rr = r[16:0]; s = sa + sb; v = (s > 32767) || (s < -32768); end
      4'd1: begin r = ua - ub; rr = {ua < ub, r[15:0]}; s = sa - sb; v = (s > 32767) || (s < -32768); end
      4'd2: rr = {1'b0, ra & rb};
      4'd3: rr = {1'b0, ra | rb};
      4'd4: rr = {1'b0, ra ^ rb};
      4'd5: rr = {1'b0, ~ra};
      4'd6: begin r = ua * (1 << n); rr = r[16:0]; end
      4'd7: begin r = ua / (1 << n); rr = r[16:0]; end
      4'd8: begin r = ua + 1; rr = r[16:0]; v = (sa + 1) > 32767; end
      4'd9: begin r = ua - 1; rr = {ua == 0, r[15:0]}; v = (sa - 1) < -32768; end
      4'd10: rr = {1'b0, ra};
      4'd11: rr = {1'b0, rb};
      default: rr = '0;
    endcase
    return {rr, rr[15:0] == 16'h0, rr[15], rr[16], v};
  endfunction

  // Drive at negedge, sample #1 after the capturing posedge.
  task automatic apply(input logic [15:0] ta, tb, input logic [3:0] top);
    @(negedge clk);
    a = ta; b = tb; op = top;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ra, rb;
    logic [15:0] va, vb;
    logic [3:0]  vo;
    logic [20:0] held;
    rst = 1'b1; a = '0; b = '0; op = '0;
    #12;
    chk("reset_state", obs(), '0);
    @(negedge clk);
    rst = 1'b0;

    // Reset mid-operation clears outputs without a clock edge.
    apply(16'h1234, 16'h0, 4'd10);
    chk("passa_pre_reset", obs(), mk(17'h01234, 0, 0, 0, 0));
    #2 rst = 1'b1;
    #1 chk("async_reset", obs(), '0);
    @(posedge clk); #1;
    chk("reset_holds_over_edge", obs(), '0);
    @(negedge clk) rst = 1'b0;

    apply(16'd3, 16'd4, 4'd0);
    chk("add_3_4", obs(), mk(17'h00007, 0, 0, 0, 0));

    // Inputs moving between edges must not disturb outputs.
    held = obs();
    a = 16'hFFFF; b = 16'hFFFF; op = 4'd1;
    #2 chk("hold_between_edges", obs(), held);

    apply(16'h7FFF, 16'd1, 4'd0);  chk("add_ovf",  obs(), mk(17'h08000, 0, 1, 0, 1));
    apply(16'd5, 16'd9, 4'd1);     chk("sub_brw",  obs(), mk(17'h1FFFC, 0, 1, 1, 0));
    apply(16'hFFFF, 16'd1, 4'd0);  chk("add_wrap", obs(), mk(17'h10000, 1, 0, 1, 0));
    apply(16'h0, 16'd1, 4'd1);     chk("sub_0_1",  obs(), mk(17'h1FFFF, 0, 1, 1, 0));
    apply(16'h8000, 16'd1, 4'd1);  chk("sub_ovf",  obs(), mk(17'h07FFF, 0, 0, 0, 1));
    apply(16'hF0F0, 16'h0FF0, 4'd2); chk("and", obs(), mk(17'h000F0, 0, 0, 0, 0));
    apply(16'hF0F0, 16'h0FF0, 4'd3); chk("or",  obs(), mk(17'h0FFF0, 0, 1, 0, 0));
    apply(16'hF0F0, 16'h0FF0, 4'd4); chk("xor", obs(), mk(17'h0FF00, 0, 1, 0, 0));
    apply(16'hF0F0, 16'h0FF0, 4'd5); chk("not", obs(), mk(17'h00F0F, 0, 0, 0, 0));
    apply(16'h8001, 16'd1, 4'd6);  chk("shl1",   obs(), mk(17'h10002, 0, 0, 1, 0));
    apply(16'h8001, 16'd1, 4'd7);  chk("shr1",   obs(), mk(17'h04000, 0, 0, 0, 0));
    apply(16'h8001, 16'd0, 4'd6);  chk("shl0",   obs(), mk(17'h08001, 0, 1, 0, 0));
    apply(16'h8001, 16'd0, 4'd7);  chk("shr0",   obs(), mk(17'h08001, 0, 1, 0, 0));
    apply(16'h0003, 16'd15, 4'd6); chk("shl15",  obs(), mk(17'h18000, 0, 1, 1, 0));
    apply(16'hFFFF, 16'd0, 4'd8);  chk("inc_wrap", obs(), mk(17'h10000, 1, 0, 1, 0));
    apply(16'h7FFF, 16'd0, 4'd8);  chk("inc_ovf",  obs(), mk(17'h08000, 0, 1, 0, 1));
    apply(16'h0000, 16'd0, 4'd9);  chk("dec_zero", obs(), mk(17'h1FFFF, 0, 1, 1, 0));
    apply(16'h8000, 16'd0, 4'd9);  chk("dec_ovf",  obs(), mk(17'h07FFF, 0, 0, 0, 1));
    apply(16'h0, 16'h1234, 4'd11); chk("passb",    obs(), mk(17'h01234, 0, 0, 0, 0));
    apply(16'h5555, 16'hAAAA, 4'd13); chk("rsvd13", obs(), mk(17'h00000, 1, 0, 0, 0));
    apply(16'hFFFF, 16'hFFFF, 4'd15); chk("rsvd15", obs(), mk(17'h00000, 1, 0, 0, 0));

    // Back-to-back small signed operands, ops 0..7.
    for (int i = 0; i < 11; i++) begin
      ra = int'($urandom_range(18)) - 9;
      rb = int'($urandom_range(18)) - 9;
      va = ra[15:0]; vb = rb[15:0]; vo = 4'($urandom_range(7));
      apply(va, vb, vo);
      chk($sformatf("rand_small%0d_op%0d", i, vo), obs(), ref_model(va, vb, vo));
    end

    // Full-range random over every opcode.
    for (int i = 0; i < 200; i++) begin
      va = 16'($urandom); vb = 16'($urandom); vo = 4'($urandom_range(15));
      apply(va, vb, vo);
      chk($sformatf("rand_full%0d_op%0d", i, vo), obs(), ref_model(va, vb, vo));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
